draw_scheduler: RTL and testbench

Sequencer that shares the single VGA adapter pixel-write port (x, y, colour, plot) between several on-screen boxes. On each frame tick it snapshots every object's position, erases each box at its previous position in background colour, then redraws it at its new position, one pixel per clock. It sits between game logic (object positions) and the 160x120 VGA adapter, replacing ad-hoc per-object plotting.

---
 rtl/draw_sched_pkg.sv | 30 +++
 rtl/box_rasterizer.sv | 91 +++++++++
 rtl/draw_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_draw_scheduler.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/draw_sched_pkg.sv
// Shared types and screen constants for the draw scheduler and its box rasterizer.
package draw_sched_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned COL_W    = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_ERASE,
    ST_DRAW,
    ST_NEXT,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [COL_W-1:0] colour;
  } pixel_t;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/box_rasterizer.sv
// Walks a BOX_W x BOX_H box row-major, one registered pixel per clock, clipping to the screen.
// done is combinational: high in the cycle the last pixel is being issued.
module box_rasterizer
  import draw_sched_pkg::*;
#(
  parameter int unsigned BOX_W = 4,
  parameter int unsigned BOX_H = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [X_W-1:0]   bx,
  input  logic [Y_W-1:0]   by,
  input  logic [COL_W-1:0] colour_in,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic [COL_W-1:0] colour,
  output logic             plot,
  output logic             done
);

  localparam int unsigned CW  = cnt_w(BOX_W);
  localparam int unsigned RW  = cnt_w(BOX_H);
  localparam int unsigned PXW = X_W + 1;
  localparam int unsigned PYW = Y_W + 1;

  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic           active_q, active_d;
  pixel_t         pix_q, pix_d;
  logic           plot_q, plot_d;
  logic           run, last_col, last_row;
  logic [PXW-1:0] px;
  logic [PYW-1:0] py;

  // Counters rest at zero between boxes, so a start always begins at (0,0).
  always_comb begin
    run      = start | active_q;
    last_col = (col_q == CW'(BOX_W - 1));
    last_row = (row_q == RW'(BOX_H - 1));
    px       = {1'b0, bx} + PXW'(col_q);
    py       = {1'b0, by} + PYW'(row_q);
    col_d    = col_q;
    row_d    = row_q;
    active_d = active_q;
    pix_d    = '0;
    plot_d   = 1'b0;
    if (run) begin
      pix_d.x      = px[X_W-1:0];
      pix_d.y      = py[Y_W-1:0];
      pix_d.colour = colour_in;
      plot_d       = (px < PXW'(SCREEN_W)) && (py < PYW'(SCREEN_H));
      if (last_col) begin
        col_d = '0;
        if (last_row) begin
          row_d    = '0;
          active_d = 1'b0;
        end else begin
          row_d    = row_q + 1'b1;
          active_d = 1'b1;
        end
      end else begin
        col_d    = col_q + 1'b1;
        active_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      col_q    <= '0;
      row_q    <= '0;
      active_q <= 1'b0;
      pix_q    <= '0;
      plot_q   <= 1'b0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      active_q <= active_d;
      pix_q    <= pix_d;
      plot_q   <= plot_d;
    end
  end

  assign done   = run & last_col & last_row;
  assign x      = pix_q.x;
  assign y      = pix_q.y;
  assign colour = pix_q.colour;
  assign plot   = plot_q;

endmodule

// File: rtl/draw_scheduler.sv
// Frame sequencer sharing one VGA pixel port: per object, erase old box then draw new box.
// Optional DRAW_SCHED_SKIP_STATIC_EN skips objects whose position and colour are unchanged.
module draw_scheduler
  import draw_sched_pkg::*;
#(
  parameter int unsigned     NUM_OBJ   = 2,
  parameter int unsigned     BOX_W     = 4,
  parameter int unsigned     BOX_H     = 4,
  parameter logic [COL_W-1:0] BG_COLOUR = 3'b000
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     frame_tick,
  input  logic [X_W*NUM_OBJ-1:0]   obj_x,
  input  logic [Y_W*NUM_OBJ-1:0]   obj_y,
  input  logic [COL_W*NUM_OBJ-1:0] obj_colour,
  output logic [X_W-1:0]           x,
  output logic [Y_W-1:0]           y,
  output logic [COL_W-1:0]         colour,
  output logic                     plot,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overrun
);

  localparam int unsigned IW = cnt_w(NUM_OBJ);

  state_e                          state_q, state_d, entry_st;
  logic [IW-1:0]                   idx_q, idx_d, ent_idx;
  logic [NUM_OBJ-1:0][X_W-1:0]     sh_x_q, sh_x_d, prev_x_q, prev_x_d;
  logic [NUM_OBJ-1:0][Y_W-1:0]     sh_y_q, sh_y_d, prev_y_q, prev_y_d;
  logic [NUM_OBJ-1:0][COL_W-1:0]   sh_c_q, sh_c_d;
  logic [NUM_OBJ-1:0]              pv_q, pv_d;
  logic                            start_q, start_d;
  logic                            busy_q, busy_d;
  logic                            frame_done_q, frame_done_d;
  logic                            overrun_q, overrun_d;
  logic [X_W-1:0]                  r_bx;
  logic [Y_W-1:0]                  r_by;
  logic [COL_W-1:0]                r_col;
  logic                            r_done;
`ifdef DRAW_SCHED_SKIP_STATIC_EN
  logic [NUM_OBJ-1:0][COL_W-1:0]   prev_c_q, prev_c_d;
  logic [X_W-1:0]                  ent_x;
  logic [Y_W-1:0]                  ent_y;
  logic [COL_W-1:0]                ent_c;
`endif

  // State to enter for the next object: ERASE if it has a previous box, otherwise DRAW.
  always_comb begin
    ent_idx  = (state_q == ST_LATCH) ? '0 : idx_q + 1'b1;
    entry_st = pv_q[ent_idx] ? ST_ERASE : ST_DRAW;
`ifdef DRAW_SCHED_SKIP_STATIC_EN
    // In LATCH the shadow is being loaded this cycle, so object 0 compares against the live inputs.
    ent_x = (state_q == ST_LATCH) ? obj_x[X_W-1:0]     : sh_x_q[ent_idx];
    ent_y = (state_q == ST_LATCH) ? obj_y[Y_W-1:0]     : sh_y_q[ent_idx];
    ent_c = (state_q == ST_LATCH) ? obj_colour[COL_W-1:0] : sh_c_q[ent_idx];
    if (pv_q[ent_idx] && (ent_x == prev_x_q[ent_idx]) && (ent_y == prev_y_q[ent_idx])
        && (ent_c == prev_c_q[ent_idx])) begin
      entry_st = ST_NEXT;
    end
`endif
  end

  always_comb begin
    if (state_q == ST_ERASE) begin
      r_bx  = prev_x_q[idx_q];
      r_by  = prev_y_q[idx_q];
      r_col = BG_COLOUR;
    end else begin
      r_bx  = sh_x_q[idx_q];
      r_by  = sh_y_q[idx_q];
      r_col = sh_c_q[idx_q];
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sh_x_d   = sh_x_q;
    sh_y_d   = sh_y_q;
    sh_c_d   = sh_c_q;
    prev_x_d = prev_x_q;
    prev_y_d = prev_y_q;
    pv_d     = pv_q;
`ifdef DRAW_SCHED_SKIP_STATIC_EN
    prev_c_d = prev_c_q;
`endif
    case (state_q)
      ST_IDLE: if (frame_tick) state_d = ST_LATCH;
      ST_LATCH: begin
        for (int unsigned i = 0; i < NUM_OBJ; i++) begin
          sh_x_d[i] = obj_x[i*X_W +: X_W];
          sh_y_d[i] = obj_y[i*Y_W +: Y_W];
          sh_c_d[i] = obj_colour[i*COL_W +: COL_W];
        end
        idx_d   = '0;
        state_d = entry_st;
      end
      ST_ERASE: if (r_done) state_d = ST_DRAW;
      ST_DRAW:  if (r_done) state_d = ST_NEXT;
      ST_NEXT: begin
        prev_x_d[idx_q] = sh_x_q[idx_q];
        prev_y_d[idx_q] = sh_y_q[idx_q];
`ifdef DRAW_SCHED_SKIP_STATIC_EN
        prev_c_d[idx_q] = sh_c_q[idx_q];
`endif
        pv_d[idx_q] = 1'b1;
        if (idx_q == IW'(NUM_OBJ - 1)) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = ent_idx;
          state_d = entry_st;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Outputs are registered from the next state so they line up with the state they describe.
    start_d      = (state_d != state_q) && ((state_d == ST_ERASE) || (state_d == ST_DRAW));
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_DONE);
    overrun_d    = frame_tick && (state_q != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      sh_x_q       <= '0;
      sh_y_q       <= '0;
      sh_c_q       <= '0;
      prev_x_q     <= '0;
      prev_y_q     <= '0;
      pv_q         <= '0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef DRAW_SCHED_SKIP_STATIC_EN
      prev_c_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      sh_x_q       <= sh_x_d;
      sh_y_q       <= sh_y_d;
      sh_c_q       <= sh_c_d;
      prev_x_q     <= prev_x_d;
      prev_y_q     <= prev_y_d;
      pv_q         <= pv_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
`ifdef DRAW_SCHED_SKIP_STATIC_EN
      prev_c_q     <= prev_c_d;
`endif
    end
  end

  box_rasterizer #(
    .BOX_W(BOX_W),
    .BOX_H(BOX_H)
  ) u_raster (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start_q),
    .bx       (r_bx),
    .by       (r_by),
    .colour_in(r_col),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .plot     (plot),
    .done     (r_done)
  );

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler with default parameters (2 objects, 4x4 boxes).
module tb_draw_scheduler;

`ifdef DRAW_SCHED_SKIP_STATIC_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn, frame_tick;
  logic [15:0] obj_x;
  logic [13:0] obj_y;
  logic [5:0]  obj_colour;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot, busy, frame_done, overrun;

  always #5 clk = ~clk;

  draw_scheduler dut (
    .clk       (clk),
    .resetn    (resetn),
    .frame_tick(frame_tick),
    .obj_x     (obj_x),
    .obj_y     (obj_y),
    .obj_colour(obj_colour),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot),
    .busy      (busy),
    .frame_done(frame_done),
    .overrun   (overrun)
  );

  int checks = 0;
  int errors = 0;

  logic [17:0] exp_q[$];
  logic [17:0] got_q[$];
  bit          m_pv[2];
  int          m_px[2], m_py[2], m_pc[2];
  int          exp_done;
  int          done_cyc, busy_cyc, ovr_cnt, ovr_cyc, first_plot;
  logic        after_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic set_obj(input int i, input int ox, input int oy, input int oc);
    obj_x[i*8 +: 8]      = 8'(ox);
    obj_y[i*7 +: 7]      = 7'(oy);
    obj_colour[i*3 +: 3] = 3'(oc);
  endtask

  task automatic add_box(input int bx, input int by, input int c);
    for (int r = 0; r < 4; r++)
      for (int cc = 0; cc < 4; cc++)
        if ((bx + cc) < 160 && (by + r) < 120)
          exp_q.push_back({8'(bx + cc), 7'(by + r), 3'(c)});
  endtask

  // Expected pixel stream and frame length from the current inputs and the remembered boxes.
  task automatic model_frame();
    int nx, ny, nc;
    exp_q.delete();
    exp_done = 2;
    for (int i = 0; i < 2; i++) begin
      nx = int'(obj_x[i*8 +: 8]);
      ny = int'(obj_y[i*7 +: 7]);
      nc = int'(obj_colour[i*3 +: 3]);
      if (SKIP && m_pv[i] && nx == m_px[i] && ny == m_py[i] && nc == m_pc[i]) begin
        exp_done += 1;
      end else begin
        if (m_pv[i]) begin
          add_box(m_px[i], m_py[i], 0);
          exp_done += 16;
        end
        add_box(nx, ny, nc);
        exp_done += 17;
      end
      m_pv[i] = 1'b1;
      m_px[i] = nx;
      m_py[i] = ny;
      m_pc[i] = nc;
    end
  endtask

  // Called in an idle cycle; returns in the idle cycle following DONE.
  task automatic run_frame(input int tick_again);
    got_q.delete();
    done_cyc = -1; busy_cyc = 0; ovr_cnt = 0; ovr_cyc = -1; first_plot = -1;
    frame_tick = 1'b1;
    for (int n = 1; n <= 200 && done_cyc < 0; n++) begin
      @(posedge clk); #1;
      frame_tick = (n == tick_again);
      if (busy) busy_cyc++;
      if (plot) begin
        got_q.push_back({x, y, colour});
        if (first_plot < 0) first_plot = n;
      end
      if (overrun) begin ovr_cnt++; ovr_cyc = n; end
      if (frame_done) done_cyc = n;
    end
    frame_tick = 1'b0;
    @(posedge clk); #1;
    after_busy = busy;
  endtask

  task automatic check_frame(input string tag, input int exp_ovr);
    int mm;
    mm = -1;
    if (got_q.size() == exp_q.size())
      foreach (got_q[i]) if (got_q[i] !== exp_q[i] && mm < 0) mm = i;
    check({tag, "_done_cycle"}, done_cyc, exp_done);
    check({tag, "_busy_cycles"}, busy_cyc, exp_done);
    check({tag, "_overruns"}, ovr_cnt, exp_ovr);
    check({tag, "_num_plots"}, got_q.size(), exp_q.size());
    check({tag, "_first_bad_pixel"}, mm, -1);
    check({tag, "_idle_after"}, after_busy, 0);
  endtask

  initial begin
    resetn = 1'b0;
    frame_tick = 1'b0;
    obj_x = '0; obj_y = '0; obj_colour = '0;
    for (int i = 0; i < 2; i++) begin m_pv[i] = 1'b0; m_px[i] = 0; m_py[i] = 0; m_pc[i] = 0; end
    set_obj(0, 10, 20, 3'b100);
    set_obj(1, 50, 60, 3'b010);
    repeat (2) @(posedge clk);
    #1;
    check("rst_pixel", {x, y, colour, plot}, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {frame_done, overrun}, 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // First frame: nothing to erase, 36 cycles, first pixel two cycles after LATCH.
    model_frame();
    run_frame(0);
    check_frame("A", 0);
    check("A_first_plot_cycle", first_plot, 3);
    check("A_len_hand", done_cyc, 36);

    // obj0 moves right by one: erase old box then draw new, back-to-back with frame A.
    set_obj(0, 11, 20, 3'b100);
    model_frame();
    run_frame(0);
    check_frame("B", 0);

    // Box hanging off the bottom-right corner: only 4 pixels visible, same timing.
    set_obj(0, 158, 118, 3'b100);
    model_frame();
    run_frame(0);
    check_frame("C", 0);

    // Second tick mid-frame: one overrun pulse one cycle later, no extra frame.
    set_obj(0, 30, 30, 3'b100);
    model_frame();
    run_frame(5);
    check_frame("D", 1);
    check("D_overrun_cycle", ovr_cyc, 6);
    busy_cyc = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (busy) busy_cyc++;
    end
    check("D_no_extra_frame", busy_cyc, 0);

    // Reset in the middle of drawing obj0 at (40,40).
    set_obj(0, 40, 40, 3'b100);
    frame_tick = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      @(posedge clk); #1;
      frame_tick = 1'b0;
    end
    check("E_mid_draw_plot", plot, 1);
    check("E_mid_draw_xy", {x, y}, {8'd42, 7'd41});
    check("E_mid_draw_colour", colour, 3'b100);
    resetn = 1'b0;
    @(posedge clk); #1;
    check("E_rst_pixel", {x, y, colour, plot}, 0);
    check("E_rst_flags", {busy, frame_done, overrun}, 0);
    resetn = 1'b1;
    for (int i = 0; i < 2; i++) m_pv[i] = 1'b0;
    @(posedge clk); #1;

    // After reset nothing is erased.
    model_frame();
    run_frame(0);
    check_frame("E", 0);
    check("E_len_hand", done_cyc, 36);

    // Identical frame started in the idle cycle right after DONE.
    model_frame();
    run_frame(0);
    check_frame("F", 0);
    if (SKIP) check("F_static_plots", got_q.size(), 0);
    else      check("F_len_hand", done_cyc, 68);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
